// File: rtl/conv_frame_encoder.sv
// Frame-based convolutional encoder: latches a frame and configuration, then emits one
// rate-wide symbol per information bit followed by K-1 zero tail bits under valid/ready flow control.
module conv_frame_encoder #(
    parameter int FRAME_LEN     = 16,
    parameter int MAX_CODE_RATE = 3,
    parameter int MAX_K         = 9
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [1:0]                       i_code_rate,
    input  logic [3:0]                       i_constr_len,
    input  logic [MAX_CODE_RATE*MAX_K-1:0]   i_gen_poly,
    input  logic                             i_start,
    input  logic [FRAME_LEN-1:0]             i_data_frame,
    input  logic                             i_sym_ready,
    output logic [MAX_CODE_RATE-1:0]         o_sym,
    output logic                             o_sym_valid,
    output logic                             o_sym_last,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_cfg_err
);

    localparam int CNT_W = $clog2(FRAME_LEN + MAX_K + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ENCODE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                           r_state;
    logic [1:0]                       r_rate;
    logic [3:0]                       r_k;
    logic [MAX_CODE_RATE*MAX_K-1:0]   r_poly;
    logic [FRAME_LEN-1:0]             r_frame;
    logic [MAX_K-2:0]                 r_hist;
    logic [CNT_W-1:0]                 r_cnt;
    logic [MAX_CODE_RATE-1:0]         r_sym;
    logic                             r_sym_valid;
    logic                             r_sym_last;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_cfg_err;

    logic                             w_cfg_legal;
    logic                             w_load;
    logic [FRAME_LEN-1:0]             w_frame_shift;
    logic [MAX_K-2:0]                 w_hist_shift;
    logic [MAX_K-1:0]                 w_win;
    logic [MAX_K-1:0]                 w_kmask;
    logic [MAX_CODE_RATE-1:0]         w_next_sym;
    logic [CNT_W-1:0]                 w_cnt_adv;
    logic [CNT_W-1:0]                 w_total;
    logic                             w_next_last;

    assign w_cfg_legal = (i_code_rate >= 2'd2) && (32'(i_code_rate) <= MAX_CODE_RATE)
                      && (i_constr_len >= 4'd3) && (32'(i_constr_len) <= MAX_K);

    // The frame register shifts in zeros, so once the information bits are exhausted
    // its MSB naturally supplies the zero tail bits.
    assign w_load        = (r_state == S_LOAD);
    assign w_frame_shift = r_frame << 1;
    assign w_hist_shift  = {r_hist[MAX_K-3:0], r_frame[FRAME_LEN-1]};
    assign w_win         = w_load ? {r_hist, r_frame[FRAME_LEN-1]}
                                  : {w_hist_shift, w_frame_shift[FRAME_LEN-1]};

    assign w_cnt_adv   = r_cnt + CNT_W'(1);
    assign w_total     = FRAME_LEN_C + CNT_W'(r_k) - CNT_W'(1);
    assign w_next_last = !w_load && (w_cnt_adv == (w_total - CNT_W'(1)));

    genvar gi;
    generate
        for (gi = 0; gi < MAX_K; gi++) begin : g_kmask
            assign w_kmask[gi] = (4'(gi) < r_k);
        end
        for (gi = 0; gi < MAX_CODE_RATE; gi++) begin : g_sym
            assign w_next_sym[gi] = (2'(gi) < r_rate)
                                 && (^(w_win & w_kmask & r_poly[gi*MAX_K +: MAX_K]));
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rate      <= '0;
            r_k         <= '0;
            r_poly      <= '0;
            r_frame     <= '0;
            r_hist      <= '0;
            r_cnt       <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else if (en) begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_legal) begin
                            r_state <= S_LOAD;
                            r_rate  <= i_code_rate;
                            r_k     <= i_constr_len;
                            r_poly  <= i_gen_poly;
                            r_frame <= i_data_frame;
                            r_hist  <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state     <= S_ENCODE;
                    r_sym       <= w_next_sym;
                    r_sym_valid <= 1'b1;
                    r_sym_last  <= 1'b0;
                end
                S_ENCODE, S_FLUSH: begin
                    if (i_sym_ready) begin
                        r_hist  <= w_hist_shift;
                        r_frame <= w_frame_shift;
                        r_cnt   <= w_cnt_adv;
                        if (w_cnt_adv == w_total) begin
                            r_state     <= S_DONE;
                            r_sym       <= '0;
                            r_sym_valid <= 1'b0;
                            r_sym_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            if (w_cnt_adv == FRAME_LEN_C) begin
                                r_state <= S_FLUSH;
                            end
                            r_sym      <= w_next_sym;
                            r_sym_last <= w_next_last;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sym       = r_sym;
    assign o_sym_valid = r_sym_valid;
    assign o_sym_last  = r_sym_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Scoreboard bench for conv_frame_encoder: a reference shift-register encoder queues the
// expected {last, symbol} stream and every accepted symbol is compared against it.
module tb_conv_frame_encoder;

    localparam int FL = 16;
    localparam int MR = 3;
    localparam int MK = 9;
    localparam int PW = MR * MK;

    logic           sys_clk = 1'b0;
    logic           rst;
    logic           en;
    logic [1:0]     i_code_rate;
    logic [3:0]     i_constr_len;
    logic [PW-1:0]  i_gen_poly;
    logic           i_start;
    logic [FL-1:0]  i_data_frame;
    logic           i_sym_ready;
    logic [MR-1:0]  o_sym;
    logic           o_sym_valid;
    logic           o_sym_last;
    logic           o_busy;
    logic           o_done;
    logic           o_cfg_err;

    conv_frame_encoder #(.FRAME_LEN(FL), .MAX_CODE_RATE(MR), .MAX_K(MK)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .en           (en),
        .i_code_rate  (i_code_rate),
        .i_constr_len (i_constr_len),
        .i_gen_poly   (i_gen_poly),
        .i_start      (i_start),
        .i_data_frame (i_data_frame),
        .i_sym_ready  (i_sym_ready),
        .o_sym        (o_sym),
        .o_sym_valid  (o_sym_valid),
        .o_sym_last   (o_sym_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cfg_err    (o_cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    logic [MR:0] exp_q[$];
    logic [MR:0] obs_q[$];
    int          cyc = 0;
    int          done_cnt, err_cnt, first_cyc, last_cyc, done_cyc, start_cyc, stall_viol;
    bit          busy_seen, prev_hold, timed_out;
    logic [MR-1:0] prev_sym;
    logic        prev_last;

    localparam logic [FL-1:0] BASIC_FRAME = 16'b1101101010100110;
    localparam logic [PW-1:0] BASIC_POLY  = {9'd0, 9'b000000101, 9'b000000111};

    // Reference encoder: sr[0] is the current bit, sr[i] the bit i steps earlier.
    function automatic void push_model(input logic [FL-1:0] frame, input int k,
                                       input int rate, input logic [PW-1:0] poly);
        logic [MK-1:0] sr;
        logic [MR-1:0] sym;
        logic          b;
        int            total;
        sr    = '0;
        total = FL + k - 1;
        for (int n = 0; n < total; n++) begin
            b   = (n < FL) ? frame[FL-1-n] : 1'b0;
            sr  = {sr[MK-2:0], b};
            sym = '0;
            for (int j = 0; j < rate; j++)
                for (int i = 0; i < k; i++)
                    sym[j] = sym[j] ^ (sr[i] & poly[j*MK+i]);
            exp_q.push_back({(n == total - 1), sym});
        end
    endfunction

    // Sample at the falling edge, then return just after the next rising edge.
    task automatic step();
        @(negedge sys_clk);
        cyc++;
        if (o_busy) busy_seen = 1;
        if (o_done && en) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (o_cfg_err && en) err_cnt++;
        if (prev_hold && (!o_sym_valid || o_sym !== prev_sym || o_sym_last !== prev_last))
            stall_viol++;
        if (o_sym_valid && i_sym_ready && en) begin
            obs_q.push_back({o_sym_last, o_sym});
            if (first_cyc < 0) first_cyc = cyc;
            if (o_sym_last) last_cyc = cyc;
        end
        prev_hold = o_sym_valid && !(i_sym_ready && en);
        prev_sym  = o_sym;
        prev_last = o_sym_last;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_run();
        obs_q.delete();
        done_cnt = 0; err_cnt = 0; stall_viol = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1; start_cyc = -1;
        busy_seen = 0; prev_hold = 0; timed_out = 0;
    endtask

    // mode 0: ready held high, 1: ready toggles each cycle, 2: en low for 3 cycles mid-frame.
    task automatic run_frame(input int mode);
        int n;
        bit paused;
        clear_run();
        i_start = 1'b1;
        step();
        start_cyc = cyc;
        i_start = 1'b0;
        i_gen_poly   = ~i_gen_poly;
        i_data_frame = ~i_data_frame;
        i_constr_len = 4'd5;
        n = 0;
        paused = 0;
        while (done_cnt == 0 && n < 400) begin
            if (mode == 1) i_sym_ready = ~i_sym_ready;
            if (mode == 2 && !paused && obs_q.size() == 5) begin
                en = 1'b0;
                step(); step(); step();
                en = 1'b1;
                paused = 1;
            end
            step();
            n++;
        end
        timed_out   = (done_cnt == 0);
        i_sym_ready = 1'b1;
    endtask

    task automatic set_cfg(input int rate, input int k, input logic [PW-1:0] poly,
                           input logic [FL-1:0] frame);
        i_code_rate  = 2'(rate);
        i_constr_len = 4'(k);
        i_gen_poly   = poly;
        i_data_frame = frame;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (o_sym !== '0)      begin failures++; $display("FAIL reset_sym got=%b want=000", o_sym); end
        checks++; if (o_sym_valid !== 0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_sym_valid); end
        checks++; if (o_sym_last !== 0)  begin failures++; $display("FAIL reset_last got=%b want=0", o_sym_last); end
        checks++; if (o_busy !== 0)      begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        checks++; if (o_done !== 0)      begin failures++; $display("FAIL reset_done got=%b want=0", o_done); end
        checks++; if (o_cfg_err !== 0)   begin failures++; $display("FAIL reset_cfg_err got=%b want=0", o_cfg_err); end
        rst = 1'b0;
        step();
        checks++; if (o_busy !== 0 || o_sym_valid !== 0) begin failures++; $display("FAIL idle_after_reset busy=%b valid=%b want 0/0", o_busy, o_sym_valid); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [MR:0] e, o;
        exp_q.delete();
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        push_model(BASIC_FRAME, 3, 2, BASIC_POLY);
        run_frame(0);
        checks++; if (timed_out)             begin failures++; $display("FAIL basic_timeout got=no_done want=done"); end
        checks++; if (obs_q.size() != 18)    begin failures++; $display("FAIL basic_count got=%0d want=18", obs_q.size()); end
        checks++; if (obs_q[0] !== 4'b0011)  begin failures++; $display("FAIL basic_sym0 got=%b want=0011", obs_q[0]); end
        checks++; if (obs_q[1] !== 4'b0010)  begin failures++; $display("FAIL basic_sym1 got=%b want=0010", obs_q[1]); end
        checks++; if (obs_q[2] !== 4'b0010)  begin failures++; $display("FAIL basic_sym2 got=%b want=0010", obs_q[2]); end
        checks++; if (obs_q[3] !== 4'b0000)  begin failures++; $display("FAIL basic_sym3 got=%b want=0000", obs_q[3]); end
        checks++; if (obs_q[17][MR] !== 1'b1) begin failures++; $display("FAIL basic_last18 got=%b want=1", obs_q[17][MR]); end
        checks++; if (first_cyc - start_cyc != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", first_cyc - start_cyc); end
        checks++; if (done_cyc != last_cyc + 1)   begin failures++; $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, last_cyc + 1); end
        checks++; if (done_cnt != 1)         begin failures++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL basic_seq got=%b want=%b", o, e); end
        end
        $display("test_basic: done");
    endtask

    task automatic test_stall();
        logic [MR:0] e, o;
        exp_q.delete();
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        push_model(BASIC_FRAME, 3, 2, BASIC_POLY);
        run_frame(1);
        checks++; if (timed_out)      begin failures++; $display("FAIL stall_timeout got=no_done want=done"); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_stable got=%0d changes want=0", stall_viol); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL stall_seq got=%b want=%b", o, e); end
        end
        $display("test_stall: done");
    endtask

    task automatic test_cfg_err();
        int rates[4] = '{1, 2, 0, 2};
        int ks[4]    = '{3, 10, 5, 2};
        for (int t = 0; t < 4; t++) begin
            clear_run();
            set_cfg(rates[t], ks[t], BASIC_POLY, BASIC_FRAME);
            i_start = 1'b1;
            step();
            i_start = 1'b0;
            repeat (4) step();
            checks++; if (err_cnt != 1)      begin failures++; $display("FAIL cfg_err_pulse rate=%0d k=%0d got=%0d want=1", rates[t], ks[t], err_cnt); end
            checks++; if (busy_seen)         begin failures++; $display("FAIL cfg_err_busy rate=%0d k=%0d got=1 want=0", rates[t], ks[t]); end
            checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL cfg_err_syms rate=%0d k=%0d got=%0d want=0", rates[t], ks[t], obs_q.size()); end
            $display("test_cfg_err: rate=%0d k=%0d", rates[t], ks[t]);
        end
    endtask

    task automatic test_zero_k9();
        logic [MR:0] e, o;
        logic [PW-1:0] poly;
        exp_q.delete();
        poly = PW'({$urandom(), $urandom()});
        set_cfg(3, 9, poly, '0);
        push_model('0, 9, 3, poly);
        run_frame(0);
        checks++; if (timed_out)               begin failures++; $display("FAIL zero_timeout got=no_done want=done"); end
        checks++; if (obs_q.size() != 24)      begin failures++; $display("FAIL zero_count got=%0d want=24", obs_q.size()); end
        checks++; if (obs_q[23] !== 4'b1000)   begin failures++; $display("FAIL zero_last got=%b want=1000", obs_q[23]); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL zero_seq got=%b want=%b", o, e); end
        end
        $display("test_zero_k9: done");
    endtask

    task automatic test_random();
        logic [MR:0] e, o;
        logic [PW-1:0] poly;
        logic [FL-1:0] frame;
        int rate, k;
        for (int t = 0; t < 3; t++) begin
            exp_q.delete();
            rate  = (t == 1) ? 2 : 3;
            k     = 3 + 2 * t + (t == 2 ? 2 : 0);
            poly  = PW'({$urandom(), $urandom()});
            frame = FL'($urandom());
            set_cfg(rate, k, poly, frame);
            push_model(frame, k, rate, poly);
            run_frame(t % 2);
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_len rate=%0d k=%0d got=%0d want=%0d", rate, k, obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++; if (o !== e) begin failures++; $display("FAIL rand_seq rate=%0d k=%0d got=%b want=%b", rate, k, o, e); end
            end
            $display("test_random: rate=%0d k=%0d frame=%h", rate, k, frame);
        end
    endtask

    task automatic test_en_freeze();
        logic [MR:0] e, o;
        exp_q.delete();
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        push_model(BASIC_FRAME, 3, 2, BASIC_POLY);
        run_frame(2);
        checks++; if (timed_out)       begin failures++; $display("FAIL freeze_timeout got=no_done want=done"); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL freeze_stable got=%0d changes want=0", stall_viol); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL freeze_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL freeze_seq got=%b want=%b", o, e); end
        end
        $display("test_en_freeze: done");
    endtask

    task automatic test_reset_midframe();
        logic [MR:0] e, o;
        int n;
        exp_q.delete();
        clear_run();
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        n = 0;
        while (obs_q.size() < 4 && n < 100) begin
            step();
            n++;
        end
        rst = 1'b1;
        #1;
        checks++; if (o_sym_valid !== 0 || o_busy !== 0 || o_sym !== '0) begin failures++; $display("FAIL midrst_outputs got valid=%b busy=%b sym=%b want 0/0/000", o_sym_valid, o_busy, o_sym); end
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt); end
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        push_model(BASIC_FRAME, 3, 2, BASIC_POLY);
        run_frame(0);
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL midrst_restart_done got=%0d want=1", done_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL midrst_seq got=%b want=%b", o, e); end
        end
        $display("test_reset_midframe: done");
    endtask

    // Start held high throughout; the second frame's configuration is applied mid-frame-one.
    task automatic test_back_to_back();
        logic [MR:0] e, o;
        logic [PW-1:0] poly_b;
        logic [FL-1:0] frame_b;
        int n;
        exp_q.delete();
        clear_run();
        poly_b  = PW'({$urandom(), $urandom()});
        frame_b = FL'($urandom());
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        push_model(BASIC_FRAME, 3, 2, BASIC_POLY);
        i_start = 1'b1;
        step();
        set_cfg(3, 4, poly_b, frame_b);
        push_model(frame_b, 4, 3, poly_b);
        n = 0;
        while (done_cnt < 2 && n < 400) begin
            step();
            n++;
        end
        i_start = 1'b0;
        checks++; if (done_cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_seq got=%b want=%b", o, e); end
        end
        step();
        $display("test_back_to_back: done");
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; i_start = 1'b0; i_sym_ready = 1'b1;
        set_cfg(2, 3, BASIC_POLY, BASIC_FRAME);
        clear_run();
        prev_sym = '0; prev_last = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_cfg_err();
        test_zero_k9();
        test_random();
        test_en_freeze();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_frame_encoder.md
CONV_FRAME_ENCODER -- requirements
Module: conv_frame_encoder

Interface
REQ-001 The block SHALL have these parameters: FRAME_LEN, default 16, meaning information bits per frame; MAX_CODE_RATE, default 3, meaning maximum output symbols per input bit; MAX_K, default 9, meaning maximum constraint length and the generator polynomial width.
REQ-002 The block SHALL use one clock, with asynchronous, active-high reset.
REQ-003 sys_clk  input  1  meaning: the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  meaning: asynchronous, active-high reset.
REQ-005 en  input  1  meaning: clock enable; when 0 all state and outputs SHALL hold.
REQ-006 i_code_rate  input  2  meaning: symbols per bit; legal values are 2 and 3.
REQ-007 i_constr_len  input  4  meaning: constraint length K; legal values are 3..MAX_K.
REQ-008 i_gen_poly  input  MAX_CODE_RATE*MAX_K  meaning: polynomial j occupies bits [j*MAX_K +: MAX_K], and bit 0 taps the current input bit.
REQ-009 i_start  input  1  meaning: frame request, sampled in IDLE only.
REQ-010 i_data_frame  input  FRAME_LEN  meaning: information bits, transmitted MSB first.
REQ-011 i_sym_ready  input  1  meaning: downstream accepts o_sym.
REQ-012 o_sym  output  MAX_CODE_RATE  meaning: encoded symbol; bit j is the output of polynomial j.
REQ-013 o_sym_valid  output  1  meaning: o_sym holds a valid symbol.
REQ-014 o_sym_last  output  1  meaning: asserted with the final tail symbol.
REQ-015 o_busy  output  1  meaning: the frame is in progress (LOAD, ENCODE or FLUSH).
REQ-016 o_done  output  1  meaning: one-cycle pulse after the last symbol is accepted.
REQ-017 o_cfg_err  output  1  meaning: one-cycle pulse when a start is rejected for illegal configuration.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, ENCODE, FLUSH and DONE, and SHALL advance only in cycles where en=1.
REQ-019 IDLE with i_start=1 and a legal configuration -> LOAD, latching rate, K, polynomials and frame, and clearing the K-1 bit history register.
REQ-020 IDLE with i_start=1 and an illegal configuration -> o_cfg_err=1 for one cycle; the state SHALL remain IDLE.
REQ-021 LOAD -> ENCODE unconditionally; o_sym_valid SHALL rise in the cycle after LOAD, giving 2 cycles from start to first symbol.
REQ-022 Window w SHALL be K bits: w[0] is the current bit, w[i] is the bit i steps earlier, and bits at K and above are treated as 0.
REQ-023 o_sym[j] SHALL be the XOR-reduce of (w AND poly j) for j < rate; o_sym[j] SHALL be 0 for j >= rate.
REQ-024 A transfer SHALL occur only when o_sym_valid=1, i_sym_ready=1 and en=1; on a transfer the history SHALL shift the current bit in and the bit index SHALL advance.
REQ-025 While o_sym_valid=1 and i_sym_ready=0, o_sym, o_sym_last and the internal state SHALL hold stable.
REQ-026 ENCODE -> FLUSH after FRAME_LEN transfers; FLUSH SHALL emit K-1 zero input bits so the trellis terminates in state 0.
REQ-027 Total symbols per frame SHALL be FRAME_LEN+K-1; o_sym_last SHALL be 1 only on the final symbol.
REQ-028 FLUSH -> DONE on the transfer of the last symbol; DONE SHALL pulse o_done=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-029 A new frame SHALL be accepted no earlier than the cycle after DONE.
REQ-030 i_start outside IDLE SHALL be ignored, and changes to configuration inputs during a frame SHALL have no effect.
REQ-031 o_busy SHALL be 1 exactly in LOAD, ENCODE and FLUSH; o_sym_valid SHALL be 1 exactly in ENCODE and FLUSH.

Reset
REQ-032 rst=1 SHALL immediately force the FSM to IDLE and clear the history, counters and latched configuration.
REQ-033 During reset all outputs SHALL be 0: o_sym, o_sym_valid, o_sym_last, o_busy, o_done and o_cfg_err.
REQ-034 Reset mid-frame SHALL abort the frame with no o_done; the next legal i_start SHALL begin a fresh frame from the cleared history.

Verification
REQ-035 Rate 2, K=3, polys 111/101, frame 16'b1101101010100110, ready=1 -> first four o_sym = 11, 10, 10, 00; 18 symbols total; o_sym_last on the 18th; o_done one cycle later.
REQ-036 Same frame with i_sym_ready toggled 0/1 every cycle -> identical symbol sequence; o_sym stable throughout every stall.
REQ-037 i_code_rate=1 or i_constr_len=10 with i_start=1 -> o_cfg_err pulse, o_busy stays 0, no symbols are emitted.
REQ-038 Rate 3, K=9, frame all zeros -> 24 symbols all 000, o_sym_last on the 24th.
REQ-039 rst pulse on the 5th symbol, then restart with the same frame -> the output matches the unreset run exactly, with no o_done from the aborted frame.
REQ-040 en=0 held for 3 cycles mid-frame -> outputs frozen, and the sequence resumes unchanged when en returns to 1.
